// File: rtl/pci_pkg.sv
// Shared simplified-PCI definitions: command codes, byte enables and the
// initiator state encoding, used by both the initiator and the target device.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;
    localparam logic [3:0] BE_ALL        = 4'b0000;
    localparam logic [3:0] BE_NONE       = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        TURN,
        DATA,
        ABORT,
        RECOVER
    } init_state_e;

    function automatic logic [3:0] mem_cmd(input logic write);
        return write ? CMD_MEM_WRITE : CMD_MEM_READ;
    endfunction

endpackage

// File: rtl/pci_initiator_if.sv
// Host command/data port plus the PCI control lines of the initiator.
// AD stays a separate inout port on the initiator because it is a tristate net.
interface pci_initiator_if #(parameter int unsigned LEN_W = 4);

    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_WRITE;
    logic [31:0]      REQ_ADDR;
    logic [LEN_W-1:0] REQ_LEN;
    logic [31:0]      WR_DATA;
    logic             WR_POP;
    logic [31:0]      RD_DATA;
    logic             RD_VALID;
    logic             DONE;
    logic             ERR;
    logic             FRAME;
    logic             IRDY;
    logic [3:0]       CBE;
    logic             TRDY;
    logic             DEVSEL;

    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, WR_DATA, TRDY, DEVSEL,
        output REQ_READY, WR_POP, RD_DATA, RD_VALID, DONE, ERR, FRAME, IRDY, CBE
    );

    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, WR_DATA, TRDY, DEVSEL,
        input  REQ_READY, WR_POP, RD_DATA, RD_VALID, DONE, ERR, FRAME, IRDY, CBE
    );

endinterface

// File: rtl/pci_abort_timer.sv
// DEVSEL timeout counter: load arms it at request accept, clear disarms it once
// DEVSEL is seen, expire holds once LIMIT clocks without DEVSEL have elapsed.
module pci_abort_timer #(
    parameter int unsigned LIMIT = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    logic [3:0] count;
    logic       armed;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            armed <= 1'b0;
            count <= '0;
        end else if (load) begin
            armed <= 1'b1;
            count <= '0;
        end else if (clear) begin
            armed <= 1'b0;
        end else if (armed && tick && !expire) begin
            count <= count + 4'd1;
        end
    end

    assign expire = armed && (count == 4'(LIMIT));

endmodule

// File: rtl/pci_initiator.sv
// Simplified PCI bus master: turns host burst requests into FRAME/IRDY/CBE/AD cycles.
// Define PCI_MASTER_ABORT_EN to enable the DEVSEL timeout and master-abort path.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int unsigned DEVSEL_TIMEOUT = 5,
    parameter int unsigned LEN_W          = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    pci_initiator_if.master        bus,
    inout  wire  [31:0]            AD
);

    localparam int unsigned CW = LEN_W + 1;

    init_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   rd_q;
    logic          frame_q, frame_n;
    logic          irdy_q, irdy_n;
    logic [3:0]    cbe_q, cbe_n;
    logic          oe_q, oe_n;
    logic          wrsel_q, wrsel_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic          rdv_q, rdv_n;
    logic          accept, beat, last, abort;

    assign accept = (state == IDLE) && bus.REQ_VALID;
    assign beat   = (state == DATA) && !bus.TRDY && !bus.DEVSEL;
    assign last   = (cnt == CW'(1));

`ifdef PCI_MASTER_ABORT_EN
    logic expire;

    pci_abort_timer #(.LIMIT(DEVSEL_TIMEOUT)) u_abort_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load   (accept),
        .clear  (!bus.DEVSEL),
        .tick   (bus.DEVSEL),
        .expire (expire)
    );

    assign abort = expire;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = DEVSEL_TIMEOUT;
    assign abort          = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        cbe_n   = BE_NONE;
        oe_n    = 1'b0;
        wrsel_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        rdv_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    state_n = ADDR;
                    cnt_n   = CW'(bus.REQ_LEN) + CW'(1);
                    frame_n = 1'b0;
                    cbe_n   = mem_cmd(bus.REQ_WRITE);
                    oe_n    = 1'b1;
                end
            end
            ADDR: begin
                state_n = wr_q ? DATA : TURN;
                frame_n = last;
                irdy_n  = 1'b0;
                cbe_n   = BE_ALL;
                oe_n    = wr_q;
                wrsel_n = wr_q;
            end
            TURN: begin
                state_n = DATA;
                frame_n = last;
                irdy_n  = 1'b0;
                cbe_n   = BE_ALL;
            end
            DATA: begin
                if (beat) begin
                    cnt_n = cnt - CW'(1);
                    rdv_n = !wr_q;
                    if (last) begin
                        state_n = RECOVER;
                        done_n  = 1'b1;
                    end else begin
                        // FRAME drops one beat early so the final beat runs with FRAME=1
                        frame_n = (cnt == CW'(2));
                        irdy_n  = 1'b0;
                        cbe_n   = BE_ALL;
                        oe_n    = wr_q;
                        wrsel_n = wr_q;
                    end
                end else if (abort) begin
                    state_n = ABORT;
                    irdy_n  = 1'b0;
                    cbe_n   = BE_ALL;
                end else begin
                    frame_n = frame_q;
                    irdy_n  = irdy_q;
                    cbe_n   = cbe_q;
                    oe_n    = oe_q;
                    wrsel_n = wrsel_q;
                end
            end
            ABORT: begin
                state_n = RECOVER;
                done_n  = 1'b1;
                err_n   = 1'b1;
            end
            RECOVER: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            rd_q    <= '0;
            frame_q <= 1'b1;
            irdy_q  <= 1'b1;
            cbe_q   <= BE_NONE;
            oe_q    <= 1'b0;
            wrsel_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            frame_q <= frame_n;
            irdy_q  <= irdy_n;
            cbe_q   <= cbe_n;
            oe_q    <= oe_n;
            wrsel_q <= wrsel_n;
            done_q  <= done_n;
            err_q   <= err_n;
            rdv_q   <= rdv_n;
            if (accept) begin
                addr_q <= bus.REQ_ADDR;
                wr_q   <= bus.REQ_WRITE;
            end
            if (beat && !wr_q) begin
                rd_q <= AD;
            end
        end
    end

    // Write data comes straight from the host word, which is held for the whole data phase
    assign AD = oe_q ? (wrsel_q ? bus.WR_DATA : addr_q) : 'z;

    assign bus.REQ_READY = (state == IDLE) && RST;
    assign bus.WR_POP    = beat && wr_q && RST;
    assign bus.RD_DATA   = rd_q;
    assign bus.RD_VALID  = rdv_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.FRAME     = frame_q;
    assign bus.IRDY      = irdy_q;
    assign bus.CBE       = cbe_q;

endmodule

// File: tb/tb_pci_initiator.sv
// Directed bench for pci_initiator: writes, waits, reads, abort/no-abort,
// reset mid-burst and back-to-back requests; AD is pulled up when released.
module tb_pci_initiator;
    import pci_pkg::*;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned TIMEOUT = 5;
    localparam logic [31:0] AD_FLOAT = 32'hFFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    tri1  [31:0] AD;
    logic        tgt_oe   = 1'b0;
    logic [31:0] tgt_data = '0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int rdvs   = 0;
    int p0, r0, wi;

    logic [31:0] words [4] = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    logic        t2_trdy  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t2_pop   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        t2_frame [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    pci_initiator_if #(.LEN_W(LEN_W)) bus ();

    assign AD = tgt_oe ? tgt_data : 'z;

    pci_initiator #(.DEVSEL_TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus),
        .AD  (AD)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.WR_POP)   pops++;
        if (bus.RD_VALID) rdvs++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic frame, input logic irdy,
                           input logic [3:0] cbe, input logic [31:0] ad);
        check({tag, ".frame"}, 32'(bus.FRAME), 32'(frame));
        check({tag, ".irdy"},  32'(bus.IRDY),  32'(irdy));
        check({tag, ".cbe"},   32'(bus.CBE),   32'(cbe));
        check({tag, ".ad"},    AD,             ad);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] len);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WRITE = w;
        bus.REQ_ADDR  = a;
        bus.REQ_LEN   = len;
    endtask

    initial begin
        bus.REQ_VALID = 1'b0;
        bus.REQ_WRITE = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_LEN   = '0;
        bus.WR_DATA   = '0;
        bus.TRDY      = 1'b1;
        bus.DEVSEL    = 1'b1;
        step();
        step();
        chk_bus("rst", 1'b1, 1'b1, BE_NONE, AD_FLOAT);
        check("rst.ready", 32'(bus.REQ_READY), 32'd0);
        check("rst.pop",   32'(bus.WR_POP),    32'd0);
        check("rst.rdv",   32'(bus.RD_VALID),  32'd0);
        check("rst.rdata", bus.RD_DATA,        32'd0);
        check("rst.done",  32'(bus.DONE),      32'd0);
        check("rst.err",   32'(bus.ERR),       32'd0);
        RST = 1'b1;
        step();
        check("idle.ready", 32'(bus.REQ_READY), 32'd1);

        // single-beat write
        p0 = pops;
        req(1'b1, 32'h0000_0000, 4'd0);
        bus.WR_DATA = 32'hDEAD_BEEF;
        bus.DEVSEL  = 1'b0;
        bus.TRDY    = 1'b0;
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        chk_bus("w1.addr", 1'b0, 1'b1, CMD_MEM_WRITE, 32'h0000_0000);
        check("w1.addr.ready", 32'(bus.REQ_READY), 32'd0);
        step();
        chk_bus("w1.data", 1'b1, 1'b0, BE_ALL, 32'hDEAD_BEEF);
        check("w1.data.pop",  32'(bus.WR_POP), 32'd1);
        check("w1.data.done", 32'(bus.DONE),   32'd0);
        step();
        chk_bus("w1.rec", 1'b1, 1'b1, BE_NONE, AD_FLOAT);
        check("w1.done", 32'(bus.DONE),   32'd1);
        check("w1.err",  32'(bus.ERR),    32'd0);
        check("w1.rec.pop", 32'(bus.WR_POP), 32'd0);
        step();
        check("w1.idle.ready", 32'(bus.REQ_READY), 32'd1);
        check("w1.idle.done",  32'(bus.DONE),      32'd0);
        check("w1.pops", 32'(pops - p0), 32'd1);

        // 4-beat write with two wait states on beat 2
        p0 = pops;
        req(1'b1, 32'h0000_2000, 4'd3);
        bus.WR_DATA = words[0];
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        chk_bus("w4.addr", 1'b0, 1'b1, CMD_MEM_WRITE, 32'h0000_2000);
        wi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            bus.TRDY    = t2_trdy[i];
            bus.WR_DATA = words[wi];
            #1;
            chk_bus($sformatf("w4.c%0d", i), t2_frame[i], 1'b0, BE_ALL, words[wi]);
            check($sformatf("w4.c%0d.pop", i), 32'(bus.WR_POP), 32'(t2_pop[i]));
            if (t2_pop[i]) wi++;
        end
        step();
        chk_bus("w4.rec", 1'b1, 1'b1, BE_NONE, AD_FLOAT);
        check("w4.done", 32'(bus.DONE), 32'd1);
        step();
        check("w4.pops", 32'(pops - p0), 32'd4);

        // 2-beat read
        r0 = rdvs;
        bus.TRDY = 1'b1;
        req(1'b0, 32'h0000_3000, 4'd1);
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        chk_bus("rd.addr", 1'b0, 1'b1, CMD_MEM_READ, 32'h0000_3000);
        step();
        chk_bus("rd.turn", 1'b0, 1'b0, BE_ALL, AD_FLOAT);
        step();
        tgt_oe   = 1'b1;
        tgt_data = 32'h1111_1111;
        bus.TRDY = 1'b0;
        #1;
        chk_bus("rd.d1", 1'b0, 1'b0, BE_ALL, 32'h1111_1111);
        check("rd.d1.rdv", 32'(bus.RD_VALID), 32'd0);
        step();
        tgt_data = 32'h2222_2222;
        #1;
        check("rd.d2.frame", 32'(bus.FRAME),    32'd1);
        check("rd.d2.rdv",   32'(bus.RD_VALID), 32'd1);
        check("rd.d2.rdata", bus.RD_DATA,       32'h1111_1111);
        step();
        tgt_oe   = 1'b0;
        bus.TRDY = 1'b1;
        #1;
        chk_bus("rd.rec", 1'b1, 1'b1, BE_NONE, AD_FLOAT);
        check("rd.done",  32'(bus.DONE),     32'd1);
        check("rd.err",   32'(bus.ERR),      32'd0);
        check("rd.rdv2",  32'(bus.RD_VALID), 32'd1);
        check("rd.rdata2", bus.RD_DATA,      32'h2222_2222);
        step();
        check("rd.idle.rdv", 32'(bus.RD_VALID), 32'd0);
        check("rd.rdvs", 32'(rdvs - r0), 32'd2);

        // DEVSEL never asserted
        p0 = pops;
        r0 = rdvs;
        bus.DEVSEL  = 1'b1;
        bus.WR_DATA = 32'h0BAD_0BAD;
        req(1'b1, 32'h0000_4000, 4'd1);
        step();
        bus.REQ_VALID = 1'b0;
`ifdef PCI_MASTER_ABORT_EN
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            step();
            check($sformatf("ab.c%0d.irdy", c), 32'(bus.IRDY), 32'd0);
            check($sformatf("ab.c%0d.done", c), 32'(bus.DONE), 32'd0);
        end
        step();
        chk_bus("ab.abort", 1'b1, 1'b0, BE_ALL, AD_FLOAT);
        check("ab.abort.done", 32'(bus.DONE), 32'd0);
        step();
        check("ab.done", 32'(bus.DONE), 32'd1);
        check("ab.err",  32'(bus.ERR),  32'd1);
        check("ab.frame", 32'(bus.FRAME), 32'd1);
        step();
        check("ab.idle.done",  32'(bus.DONE),      32'd0);
        check("ab.idle.ready", 32'(bus.REQ_READY), 32'd1);
`else
        for (int c = 1; c <= 12; c++) begin
            step();
            chk_bus($sformatf("nab.c%0d", c), 1'b0, 1'b0, BE_ALL, 32'h0BAD_0BAD);
            check($sformatf("nab.c%0d.done", c), 32'(bus.DONE), 32'd0);
        end
        RST = 1'b0;
        step();
        RST = 1'b1;
        step();
        check("nab.ready", 32'(bus.REQ_READY), 32'd1);
`endif
        check("ab.pops", 32'(pops - p0), 32'd0);
        check("ab.rdvs", 32'(rdvs - r0), 32'd0);

        // reset during beat 3 of an 8-beat write
        bus.DEVSEL = 1'b0;
        bus.TRDY   = 1'b0;
        req(1'b1, 32'h0000_4000, 4'd7);
        step();
        bus.REQ_VALID = 1'b0;
        step();
        step();
        step();
        check("mr.beat3.pop", 32'(bus.WR_POP), 32'd1);
        RST = 1'b0;
        step();
        chk_bus("mr.rst", 1'b1, 1'b1, BE_NONE, AD_FLOAT);
        check("mr.rst.done",  32'(bus.DONE),      32'd0);
        check("mr.rst.ready", 32'(bus.REQ_READY), 32'd0);
        check("mr.rst.pop",   32'(bus.WR_POP),    32'd0);
        RST        = 1'b1;
        bus.DEVSEL = 1'b1;
        bus.TRDY   = 1'b1;
        step();
        check("mr.after.done",  32'(bus.DONE),      32'd0);
        check("mr.after.ready", 32'(bus.REQ_READY), 32'd1);
        req(1'b0, 32'h0000_5000, 4'd0);
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        chk_bus("mr.new.addr", 1'b0, 1'b1, CMD_MEM_READ, 32'h0000_5000);
        step();
        chk_bus("mr.new.turn", 1'b1, 1'b0, BE_ALL, AD_FLOAT);
        step();
        tgt_oe     = 1'b1;
        tgt_data   = 32'h5555_5555;
        bus.TRDY   = 1'b0;
        bus.DEVSEL = 1'b0;
        step();
        tgt_oe     = 1'b0;
        bus.TRDY   = 1'b1;
        bus.DEVSEL = 1'b1;
        #1;
        check("mr.new.done",  32'(bus.DONE), 32'd1);
        check("mr.new.rdata", bus.RD_DATA,   32'h5555_5555);
        step();

        // two queued single-beat writes, REQ_VALID held
        bus.DEVSEL  = 1'b0;
        bus.TRDY    = 1'b0;
        bus.WR_DATA = 32'h6666_6666;
        req(1'b1, 32'h0000_6000, 4'd0);
        step();
        bus.REQ_ADDR = 32'h0000_7000;
        #1;
        chk_bus("bb.addr1", 1'b0, 1'b1, CMD_MEM_WRITE, 32'h0000_6000);
        step();
        check("bb.data1", AD, 32'h6666_6666);
        step();
        bus.WR_DATA = 32'h7777_7777;
        #1;
        check("bb.done1", 32'(bus.DONE), 32'd1);
        step();
        check("bb.idle.ready", 32'(bus.REQ_READY), 32'd1);
        check("bb.idle.frame", 32'(bus.FRAME),     32'd1);
        step();
        bus.REQ_VALID = 1'b0;
        #1;
        chk_bus("bb.addr2", 1'b0, 1'b1, CMD_MEM_WRITE, 32'h0000_7000);
        step();
        check("bb.data2", AD, 32'h7777_7777);
        check("bb.data2.pop", 32'(bus.WR_POP), 32'd1);
        step();
        check("bb.done2", 32'(bus.DONE), 32'd1);
        step();
        check("bb.end.done", 32'(bus.DONE), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_initiator.md
# pci_initiator

Bus-master (initiator) end of the team's simplified PCI bus. It accepts read or write burst requests from a host-side command port and drives FRAME/IRDY/CBE/AD. It tracks the target's DEVSEL/TRDY and moves data between AD and the host data ports. It pairs with the existing target device on the shared AD bus, using the same command codes.

## Interface
- DEVSEL_TIMEOUT, 5: clocks after the address phase to wait for DEVSEL before a master abort (range 2..15).
- LEN_W, 4: width of REQ_LEN; a burst is REQ_LEN+1 beats.
- Clocking: one clock, CLK; RST is synchronous, active-low.
- CLK  in  1  bus clock; all logic on rising edge.
- RST  in  1  synchronous active-low reset.
- REQ_VALID  in  1  host request present.
- REQ_READY  out  1  high only in IDLE; a request is accepted on an edge with VALID&READY.
- REQ_WRITE  in  1  1 = memory write (CBE 4'b0111), 0 = memory read (4'b0110).
- REQ_ADDR  in  32  target address.
- REQ_LEN  in  LEN_W  beats minus one.
- WR_DATA  in  32  current write word; the host holds it valid throughout a write data phase.
- WR_POP  out  1  one-clock pulse on each completed write beat; the host advances WR_DATA.
- RD_DATA  out  32  registered read word.
- RD_VALID  out  1  one-clock pulse; RD_DATA is valid.
- DONE  out  1  one-clock pulse at the end of a transaction.
- ERR  out  1  valid with DONE; 1 = master abort.
- FRAME, IRDY  out  1  active-low bus controls.
- CBE  out  4  command in the address phase, byte enables (4'b0000) in data phases.
- AD  inout  32  driven only when the internal output enable is set, else 32'hzzzz_zzzz.
- TRDY, DEVSEL  in  1  active-low target responses.

## Operation
- States: IDLE, ADDR, TURN, DATA, ABORT, RECOVER.
- IDLE: FRAME=1, IRDY=1, CBE=4'b1111, AD released, REQ_READY=1. On accept, latch the address, direction and beat count (REQ_LEN+1), then go to ADDR.
- ADDR, one clock: FRAME=0, IRDY=1, AD=address, CBE=command. Next state is DATA for a write, TURN for a read.
- TURN (read only), one clock: AD released, IRDY=0, CBE=4'b0000, then DATA.
- DATA, write: AD=WR_DATA, IRDY=0, CBE=4'b0000.
- DATA, read: AD released, IRDY=0, CBE=4'b0000.
- A beat completes on an edge where IRDY=0, TRDY=0 and DEVSEL=0.
  - Write beat: WR_POP pulses.
  - Read beat: RD_DATA<=AD and RD_VALID=1 on the following clock.
  - The beat counter decrements on each completed beat.
- FRAME goes to 1 in the clock when remaining beats = 1, with IRDY still 0; the final beat completes under FRAME=1, IRDY=0.
- After the final beat, go to RECOVER: FRAME=1, IRDY=1, AD released, DONE=1, ERR=0. Then go to IDLE.
- TRDY=1 inserts wait states: stay in DATA and hold AD, CBE, IRDY and FRAME unchanged.
- Master abort: the counter starts in ADDR and counts clocks with DEVSEL=1. On reaching DEVSEL_TIMEOUT, go to ABORT.
  - ABORT, one clock: FRAME=1, IRDY=0, AD released.
  - Then RECOVER with DONE=1, ERR=1. No WR_POP or RD_VALID is issued.
- DEVSEL, once seen low, is not re-checked for timeout within the transaction.
- Reset mid-transaction: on the first edge with RST=0, all outputs take reset values and the state is IDLE. Partial bursts are discarded; no DONE pulse.
- Reset values: FRAME=1, IRDY=1, CBE=4'b1111, AD released, REQ_READY=0 while RST=0 (1 after release), WR_POP=0, RD_VALID=0, RD_DATA=0, DONE=0, ERR=0.

## Timing
- Write of N beats, zero wait states: accept edge, then ADDR (1), DATA (N), RECOVER (1). That is N+2 clocks from accept to DONE; REQ_READY returns on the clock after DONE.
- Read of N beats: ADDR (1), TURN (1), DATA (N), RECOVER (1). The last RD_VALID coincides with DONE.
- Minimum spacing: one IDLE clock between transactions, so a back-to-back request is accepted the clock after DONE.
- Abort: DONE at ADDR + DEVSEL_TIMEOUT + 2 clocks.
- REQ_LEN at its maximum (all ones) gives 2^LEN_W beats; the beat counter is LEN_W+1 bits wide and does not wrap.

## Configuration
- PCI_MASTER_ABORT_EN defined: DEVSEL timeout counter and ABORT state are present, behaving as above.
- PCI_MASTER_ABORT_EN undefined:
  - no timeout counter; the initiator waits indefinitely for DEVSEL;
  - ERR is tied to 0;
  - DEVSEL_TIMEOUT is ignored.

## Structure
- Shared package pci_pkg holds:
  - CMD_MEM_READ = 4'b0110;
  - CMD_MEM_WRITE = 4'b0111;
  - BE_ALL = 4'b0000;
  - BE_NONE = 4'b1111;
  - the initiator state enum.
- The target device imports the same command constants.
- One natural sub-module, pci_abort_timer: a counter with load/clear/expire. It is instantiated only under PCI_MASTER_ABORT_EN.
- AD tristate is a single continuous assign from the registered output enable and data.

## Test plan
- Single write, ADDR=32'h0000_0000, WR_DATA=32'hDEAD_BEEF, target TRDY=0 immediately -> AD=0 with CBE=0111 for 1 clock, then AD=DEADBEEF with FRAME=1/IRDY=0, one WR_POP, DONE on clock 3 with ERR=0.
- 4-beat write, target holds TRDY=1 for 2 clocks on beat 2 -> AD/IRDY stable during the waits, 4 WR_POPs, FRAME rises only on the 4th beat.
- 2-beat read, target drives 32'h1111_1111 then 32'h2222_2222 -> TURN clock with AD released, RD_VALID pulses carrying both words in order, DONE with the last.
- DEVSEL held high, DEVSEL_TIMEOUT=5 -> ABORT clock, DONE=1 and ERR=1 seven clocks after ADDR, no WR_POP or RD_VALID. With the macro undefined -> the initiator stays in DATA.
- RST=0 asserted during beat 3 of an 8-beat write -> next clock FRAME=1, IRDY=1, AD=z, no DONE; a new request is accepted after RST=1.
- Two queued requests with REQ_VALID held high -> second ADDR phase starts exactly 2 clocks after the first DONE.
